// File: rtl/me_pkg.sv
// Shared constants, state encoding and window address helper for the
// full-search block-matching motion estimator.
package me_pkg;

  localparam int PIX_W      = 8;
  localparam int BLK        = 16;
  localparam int WIN        = 31;
  localparam int NUM_PE     = 16;
  localparam int COUNT_LAST = 4110;
  localparam int CNT_W      = 13;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  // Linear search-window address of (row + vy, col) in a WIN-wide window.
  function automatic logic [9:0] win_addr(input logic [3:0] row,
                                          input logic [3:0] vy,
                                          input logic [4:0] col);
    logic [9:0] line;
    line = {6'd0, row} + {6'd0, vy};
    return line * 10'(WIN) + {5'd0, col};
  endfunction

endpackage

// File: rtl/me_pe.sv
// One processing element: accumulates the saturating SAD of candidate
// column offset K. The reference index it works on is idx - K, so it
// reloads when idx[7:0] == K and takes the second search stream while
// the current column b has not yet reached K (its candidate column
// spilled past the right edge of the first stream).
module me_pe
  import me_pkg::*;
#(
  parameter int K = 0
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             en,
  input  logic [7:0]       idx,
  input  logic [PIX_W-1:0] r,
  input  logic [PIX_W-1:0] s1,
  input  logic [PIX_W-1:0] s2,
  output logic [PIX_W-1:0] sad
);

  logic [PIX_W-1:0] acc_q, acc_d;
  logic [PIX_W-1:0] s_sel;
  logic [PIX_W-1:0] abs_diff;
  logic [PIX_W:0]   sum;
  logic             load;

  // Select search stream, form |r-s| and the saturating load/accumulate.
  always_comb begin
    load     = (idx == 8'(K));
    s_sel    = (idx[3:0] < 4'(K)) ? s2 : s1;
    abs_diff = (r > s_sel) ? (r - s_sel) : (s_sel - r);
    sum      = {1'b0, acc_q} + {1'b0, abs_diff};
    acc_d    = acc_q;
    if (en) begin
      if (load) begin
        acc_d = abs_diff;
      end else begin
        acc_d = sum[PIX_W] ? {PIX_W{1'b1}} : sum[PIX_W-1:0];
      end
    end
  end

  // Accumulator register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign sad = acc_q;

endmodule

// File: rtl/me_top_module.sv
// Full-search motion estimator top: 16x16 reference block against a
// 31x31 window with 16 staggered PEs and one shared comparator.
// Optional macro ME_DONE_EN adds a one-cycle `done` pulse on RUN -> HOLD.
// Pipeline: count -> registered addresses -> memory data -> PE
// accumulators -> comparator registers; cnt_p1/p2/p3 track which count
// each stage is working on.
module me_top_module
  import me_pkg::*;
(
  input  logic       clock,
  input  logic       reset_n,
  input  logic       start,
  input  logic [7:0] r,
  input  logic [7:0] s1,
  input  logic [7:0] s2,
  output logic [7:0] address_r,
  output logic [9:0] address_s1,
  output logic [9:0] address_s2,
  output logic [7:0] best_dist,
  output logic [3:0] motion_x,
  output logic [3:0] motion_y
`ifdef ME_DONE_EN
  ,
  output logic       done
`endif
);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               drain_q, drain_d;
  logic [7:0]         addr_r_q, addr_r_d;
  logic [9:0]         addr_s1_q, addr_s1_d;
  logic [9:0]         addr_s2_q, addr_s2_d;
  logic               vld_p1_q, vld_p2_q, vld_p3_q;
  logic [CNT_W-1:0]   cnt_p1_q, cnt_p2_q, cnt_p3_q;
  logic [PIX_W-1:0]   r_sr_q [NUM_PE-1];
  logic [PIX_W-1:0]   r_sr_d [NUM_PE-1];
  logic [PIX_W-1:0]   best_q, best_d;
  logic [3:0]         mx_q, mx_d;
  logic [3:0]         my_q, my_d;
  logic [PIX_W-1:0]   pe_sad [NUM_PE];

  logic               issue;
  logic [7:0]         av_prev;
  logic [7:0]         cmp_idx;
  logic [3:0]         cmp_k;
  logic [3:0]         cmp_v;
  logic               cmp_fire;
  logic               last_fire;
  logic [PIX_W-1:0]   cmp_sad;

  // A new count is issued every RUN cycle until COUNT_LAST has gone out.
  assign issue = (state_q == RUN) && !drain_q;

  // Address generation for the count being issued; 0 when nothing issues.
  always_comb begin
    // {v',a'} of count-16: only the row/offset field steps back by one.
    av_prev   = count_q[11:4] - 8'd1;
    addr_r_d  = '0;
    addr_s1_d = '0;
    addr_s2_d = '0;
    if (issue) begin
      addr_r_d  = count_q[7:0];
      addr_s1_d = win_addr(count_q[7:4], count_q[11:8], {1'b0, count_q[3:0]});
      if (count_q >= CNT_W'(BLK)) begin
        addr_s2_d = win_addr(av_prev[3:0], av_prev[7:4], {1'b1, count_q[3:0]});
      end
    end
  end

  // Reference delay line feeding PE k with r delayed k cycles.
  always_comb begin
    r_sr_d[0] = r;
    for (int i = 1; i < NUM_PE - 1; i++) begin
      r_sr_d[i] = r_sr_q[i-1];
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PE; gi++) begin : g_pe
      logic [PIX_W-1:0] r_k;
      if (gi == 0) begin : g_first
        assign r_k = r;
      end else begin : g_dly
        assign r_k = r_sr_q[gi-1];
      end
      me_pe #(.K(gi)) u_pe (
        .clock   (clock),
        .reset_n (reset_n),
        .en      (vld_p2_q),
        .idx     (cnt_p2_q[7:0]),
        .r       (r_k),
        .s1      (s1),
        .s2      (s2),
        .sad     (pe_sad[gi])
      );
    end
  endgenerate

  // PE k finishes reference index 255 at count 256*v + 255 + k.
  always_comb begin
    cmp_idx   = cnt_p3_q[7:0] + 8'd1;
    cmp_k     = cmp_idx[3:0];
    cmp_v     = cnt_p3_q[11:8] - ((cmp_k == 4'd0) ? 4'd0 : 4'd1);
    cmp_fire  = (state_q == RUN) && vld_p3_q &&
                (cnt_p3_q >= CNT_W'(255)) && (cmp_idx[7:4] == 4'd0);
    last_fire = (state_q == RUN) && vld_p3_q &&
                (cnt_p3_q == CNT_W'(COUNT_LAST));
    cmp_sad   = pe_sad[cmp_k];
  end

  // Control FSM next state, counter and running-best comparator.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    drain_d = drain_q;
    best_d  = best_q;
    mx_d    = mx_q;
    my_d    = my_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          count_d = '0;
          drain_d = 1'b0;
          best_d  = {PIX_W{1'b1}};
          mx_d    = '0;
          my_d    = '0;
        end
      end
      RUN: begin
        if (count_q != CNT_W'(COUNT_LAST)) begin
          count_d = count_q + CNT_W'(1);
        end else begin
          drain_d = 1'b1;
        end
        // Strict less-than keeps the earlier candidate on ties.
        if (cmp_fire && (cmp_sad < best_q)) begin
          best_d = cmp_sad;
          mx_d   = cmp_k;
          my_d   = cmp_v;
        end
        if (last_fire) begin
          state_d = HOLD;
          count_d = '0;
          drain_d = 1'b0;
        end
      end
      HOLD: begin
        if (!start) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, address, pipeline-tracking and result registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      count_q   <= '0;
      drain_q   <= 1'b0;
      addr_r_q  <= '0;
      addr_s1_q <= '0;
      addr_s2_q <= '0;
      vld_p1_q  <= 1'b0;
      vld_p2_q  <= 1'b0;
      vld_p3_q  <= 1'b0;
      cnt_p1_q  <= '0;
      cnt_p2_q  <= '0;
      cnt_p3_q  <= '0;
      for (int i = 0; i < NUM_PE - 1; i++) begin
        r_sr_q[i] <= '0;
      end
      best_q    <= {PIX_W{1'b1}};
      mx_q      <= '0;
      my_q      <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      drain_q   <= drain_d;
      addr_r_q  <= addr_r_d;
      addr_s1_q <= addr_s1_d;
      addr_s2_q <= addr_s2_d;
      vld_p1_q  <= issue;
      vld_p2_q  <= vld_p1_q;
      vld_p3_q  <= vld_p2_q;
      cnt_p1_q  <= count_q;
      cnt_p2_q  <= cnt_p1_q;
      cnt_p3_q  <= cnt_p2_q;
      for (int i = 0; i < NUM_PE - 1; i++) begin
        r_sr_q[i] <= r_sr_d[i];
      end
      best_q    <= best_d;
      mx_q      <= mx_d;
      my_q      <= my_d;
    end
  end

`ifdef ME_DONE_EN
  logic done_q, done_d;

  assign done_d = last_fire;

  // Single-cycle completion pulse on the RUN -> HOLD edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      done_q <= 1'b0;
    end else begin
      done_q <= done_d;
    end
  end

  assign done = done_q;
`endif

  assign address_r  = addr_r_q;
  assign address_s1 = addr_s1_q;
  assign address_s2 = addr_s2_q;
  assign best_dist  = best_q;
  assign motion_x   = mx_q;
  assign motion_y   = my_q;

endmodule

// File: tb/tb_me_top_module.sv
// Bench for me_top_module: frame memories with one-cycle read latency,
// expected search results queued at start and compared at E0+4114.
module tb_me_top_module;

  typedef struct packed {
    logic [7:0] best;
    logic [3:0] mx;
    logic [3:0] my;
  } result_t;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       start;
  logic [7:0] r, s1, s2;
  logic [7:0] address_r;
  logic [9:0] address_s1, address_s2;
  logic [7:0] best_dist;
  logic [3:0] motion_x, motion_y;
`ifdef ME_DONE_EN
  logic       done;
`endif

  logic [7:0] mem_r [256];
  logic [7:0] mem_s [1024];
  result_t    exp_q [$];
  int         checks = 0;
  int         failures = 0;

  // Address probes: cycle after E0, then expected r/s1/s2 addresses.
  int ap_n  [5] = '{1, 16, 17, 18, 257};
  int ap_r  [5] = '{0, 15, 16, 17, 0};
  int ap_s1 [5] = '{0, 15, 31, 32, 31};
  int ap_s2 [5] = '{0, 0, 16, 17, 481};

  always #5 clock = ~clock;

  me_top_module dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .start      (start),
    .r          (r),
    .s1         (s1),
    .s2         (s2),
    .address_r  (address_r),
    .address_s1 (address_s1),
    .address_s2 (address_s2),
    .best_dist  (best_dist),
    .motion_x   (motion_x),
    .motion_y   (motion_y)
`ifdef ME_DONE_EN
    ,
    .done       (done)
`endif
  );

  always @(posedge clock) begin
    r  <= mem_r[address_r];
    s1 <= mem_s[address_s1];
    s2 <= mem_s[address_s2];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input int expv);
    checks++;
    assert (obs === 32'(expv)) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic chk_ne(input string tag, input logic [31:0] obs, input int expv);
    checks++;
    assert (obs !== 32'(expv)) else begin
      failures++;
      $error("FAIL %s observed=%0d expected_not=%0d", tag, obs, expv);
    end
  endtask

  // Reference full search: saturating SAD, scan v then k, strict less-than.
  function automatic result_t model();
    result_t res;
    int sad;
    res = '{best: 8'hFF, mx: 4'd0, my: 4'd0};
    for (int v = 0; v < 16; v++) begin
      for (int k = 0; k < 16; k++) begin
        sad = 0;
        for (int a = 0; a < 16; a++) begin
          for (int b = 0; b < 16; b++) begin
            int rv, sv;
            rv = int'(mem_r[16*a + b]);
            sv = int'(mem_s[(a + v)*31 + b + k]);
            sad += (rv > sv) ? rv - sv : sv - rv;
          end
        end
        if (sad > 255) sad = 255;
        if (sad < int'(res.best)) begin
          res.best = 8'(sad);
          res.mx   = 4'(k);
          res.my   = 4'(v);
        end
      end
    end
    return res;
  endfunction

  task automatic fill(input logic [7:0] rv, input logic [7:0] sv);
    for (int i = 0; i < 256; i++) mem_r[i] = rv;
    for (int i = 0; i < 1024; i++) mem_s[i] = sv;
  endtask

  task automatic fill_pattern();
    for (int i = 0; i < 256; i++) mem_r[i] = 8'(i + 1);
    for (int i = 0; i < 1024; i++) mem_s[i] = 8'hFF;
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        mem_s[(a + 9)*31 + b + 5] = 8'(16*a + b + 1);
  endtask

  task automatic run_search(input string name, input result_t expv, input int probe_n,
                            input bit addr_probe, input int hold_n);
    int last_n, unstable;
    logic [7:0] fb;
    logic [3:0] fx, fy;
    result_t got;
`ifdef ME_DONE_EN
    int done_seen;
    done_seen = 0;
`endif
    last_n = (hold_n > 4114) ? hold_n : 4114;
    unstable = 0;
    fb = '0; fx = '0; fy = '0;
    exp_q.push_back(expv);
    @(negedge clock); start = 1'b1;
    @(posedge clock);                     // E0
    @(negedge clock); if (hold_n == 0) start = 1'b0;
    for (int n = 1; n <= last_n; n++) begin
      @(posedge clock); #1;
`ifdef ME_DONE_EN
      if (done === 1'b1) done_seen++;
      if (n == 4113) chk({name, "_done_early"}, 32'(done), 0);
      if (n == 4114) chk({name, "_done"}, 32'(done), 1);
`endif
      if (addr_probe) begin
        for (int i = 0; i < 5; i++) begin
          if (n == ap_n[i]) begin
            chk($sformatf("addr_r_n%0d", n), 32'(address_r), ap_r[i]);
            chk($sformatf("addr_s1_n%0d", n), 32'(address_s1), ap_s1[i]);
            chk($sformatf("addr_s2_n%0d", n), 32'(address_s2), ap_s2[i]);
          end
        end
      end
      if (probe_n > 0 && n == probe_n - 1)
        chk_ne({name, "_before_update"}, 32'(best_dist), int'(expv.best));
      if (probe_n > 0 && n == probe_n) begin
        chk({name, "_update_best"}, 32'(best_dist), int'(expv.best));
        chk({name, "_update_mx"}, 32'(motion_x), int'(expv.mx));
        chk({name, "_update_my"}, 32'(motion_y), int'(expv.my));
      end
      if (n == 4114) begin
        if (exp_q.size() == 0) begin
          chk({name, "_scoreboard_empty"}, 32'(0), 1);
        end else begin
          got = exp_q.pop_front();
          chk({name, "_best"}, 32'(best_dist), int'(got.best));
          chk({name, "_mx"}, 32'(motion_x), int'(got.mx));
          chk({name, "_my"}, 32'(motion_y), int'(got.my));
          $display("search %s: best=%0d mv=(%0d,%0d) expected best=%0d mv=(%0d,%0d)",
                   name, best_dist, motion_x, motion_y, got.best, got.mx, got.my);
        end
        fb = best_dist; fx = motion_x; fy = motion_y;
        chk({name, "_addr_idle"}, 32'({address_r, address_s1, address_s2}), 0);
      end
      if (n > 4114) begin
        if (best_dist !== fb || motion_x !== fx || motion_y !== fy ||
            address_r !== 8'd0 || address_s1 !== 10'd0 || address_s2 !== 10'd0)
          unstable++;
      end
    end
    if (hold_n > 0) begin
      chk({name, "_hold_stable"}, 32'(unstable), 0);
      @(negedge clock); start = 1'b0;
    end
`ifdef ME_DONE_EN
    chk({name, "_done_pulses"}, 32'(done_seen), 1);
`endif
    repeat (3) @(posedge clock);
    #1;
  endtask

  initial begin
    result_t ev;
    reset_n = 1'b0;
    start   = 1'b0;
    fill(8'h00, 8'h00);
    repeat (3) @(posedge clock);
    #1;
    chk("rst_best", 32'(best_dist), 255);
    chk("rst_mv", 32'({motion_x, motion_y}), 0);
    chk("rst_addr", 32'({address_r, address_s1, address_s2}), 0);
    @(negedge clock); reset_n = 1'b1;
    @(posedge clock); #1;
    chk("idle_best", 32'(best_dist), 255);
    chk("idle_addr_r", 32'(address_r), 0);

    // All-zero memories: first candidate wins at E0+259.
    fill(8'h00, 8'h00);
    run_search("zero", '{best: 8'd0, mx: 4'd0, my: 4'd0}, 259, 1'b1, 0);

    // Exact match planted at offset (5,9).
    fill_pattern();
    run_search("pattern", '{best: 8'd0, mx: 4'd5, my: 4'd9}, 2568, 1'b0, 0);

    // Every SAD saturates: tie rule keeps (0,0) with 255.
    fill(8'hFF, 8'h00);
    run_search("saturate", '{best: 8'd255, mx: 4'd0, my: 4'd0}, 0, 1'b0, 0);

    // Random window with a slightly perturbed copy at (7,3).
    for (int i = 0; i < 1024; i++) mem_s[i] = 8'($urandom_range(0, 255));
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        mem_r[16*a + b] = mem_s[(a + 3)*31 + b + 7];
    mem_r[5]   = mem_r[5] ^ 8'h01;
    mem_r[77]  = mem_r[77] ^ 8'h02;
    mem_r[200] = mem_r[200] ^ 8'h04;
    ev = model();
    run_search("random", ev, 0, 1'b0, 0);

    // Abort mid-run with reset at count 2000.
    fill(8'h00, 8'h00);
    @(negedge clock); start = 1'b1;
    @(posedge clock);
    @(negedge clock); start = 1'b0;
    repeat (2000) @(posedge clock);
    #1;
    chk("pre_abort_best", 32'(best_dist), 0);
    reset_n = 1'b0;
    #1;
    chk("abort_best", 32'(best_dist), 255);
    chk("abort_mv", 32'({motion_x, motion_y}), 0);
    chk("abort_addr", 32'({address_r, address_s1, address_s2}), 0);
    @(negedge clock); reset_n = 1'b1;
    repeat (2) @(posedge clock);

    // Restart after abort with start held high for 10000 cycles.
    fill_pattern();
    run_search("hold", '{best: 8'd0, mx: 4'd5, my: 4'd9}, 2568, 1'b0, 10000);

    chk("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
